// File: rtl/cdb_arbiter_if.sv
// Completion-request and common-data-bus signal bundle for cdb_arbiter.
// master drives completions and flush; slave (the arbiter) drives full flags and the CDB.
interface cdb_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic                 flush;
    logic [3:0]           req_valid;
    logic [4*TAG_W-1:0]   req_tag;
    logic [4*XLEN-1:0]    req_data;
    logic [3:0]           full;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [XLEN-1:0]      cdb_data;
    logic [1:0]           cdb_src;

    modport master (
        output flush, req_valid, req_tag, req_data,
        input  full, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  flush, req_valid, req_tag, req_data,
        output full, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Serialises the int/mult/div/mem completion streams onto the single common data bus.
// Define CDB_FIXED_PRIO_EN for fixed priority div > mult > mem > int instead of round-robin.
module cdb_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    cdb_arbiter_if.slave bus
);
    localparam int NSRC  = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] tag_mem   [NSRC][DEPTH];
    logic [XLEN-1:0]  data_mem  [NSRC][DEPTH];
    logic [PTR_W-1:0] rd_ptr    [NSRC];
    logic [PTR_W-1:0] wr_ptr    [NSRC];
    logic [CNT_W-1:0] count     [NSRC];

    logic [NSRC-1:0]  full_q;
    logic [NSRC-1:0]  head_valid;
    logic [NSRC-1:0]  cand_valid;
    logic [TAG_W-1:0] cand_tag  [NSRC];
    logic [XLEN-1:0]  cand_data [NSRC];
    logic [NSRC-1:0]  win;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;

    logic             grant_valid;
    logic [1:0]       grant_idx;

    logic             cdb_valid_q;
    logic [TAG_W-1:0] cdb_tag_q;
    logic [XLEN-1:0]  cdb_data_q;
    logic [1:0]       cdb_src_q;

    // A source's candidate is its queue head; the bypass is only allowed when the queue is empty.
    always_comb begin
        for (int u = 0; u < NSRC; u++) begin
            full_q[u]     = (count[u] == CNT_W'(DEPTH));
            head_valid[u] = (count[u] != '0);
            cand_valid[u] = head_valid[u] || bus.req_valid[u];
            cand_tag[u]   = head_valid[u] ? tag_mem[u][rd_ptr[u]]
                                          : bus.req_tag[u*TAG_W +: TAG_W];
            cand_data[u]  = head_valid[u] ? data_mem[u][rd_ptr[u]]
                                          : bus.req_data[u*XLEN +: XLEN];
        end
    end

`ifdef CDB_FIXED_PRIO_EN
    // Longest-latency unit first: div > mult > mem > int.
    always_comb begin
        grant_valid = 1'b1;
        grant_idx   = 2'd0;
        if (cand_valid[2])      grant_idx = 2'd2;
        else if (cand_valid[1]) grant_idx = 2'd1;
        else if (cand_valid[3]) grant_idx = 2'd3;
        else if (cand_valid[0]) grant_idx = 2'd0;
        else                    grant_valid = 1'b0;
    end
`else
    logic [1:0] rr_ptr;
    logic [1:0] rr_idx;

    // Scan from the farthest offset down so the source nearest the pointer wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        rr_idx      = rr_ptr;
        for (int i = NSRC - 1; i >= 0; i--) begin
            rr_idx = rr_ptr + 2'(i);
            if (cand_valid[rr_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (!bus.flush && grant_valid) begin
            rr_ptr <= grant_idx + 2'd1;
        end
    end
`endif

    // A full queue refuses pushes even if it pops on the same edge.
    always_comb begin
        for (int u = 0; u < NSRC; u++) begin
            win[u]  = grant_valid && (grant_idx == 2'(u));
            pop[u]  = win[u] && head_valid[u];
            push[u] = bus.req_valid[u] && !full_q[u] && !(win[u] && !head_valid[u]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < NSRC; u++) begin
                rd_ptr[u] <= '0;
                wr_ptr[u] <= '0;
                count[u]  <= '0;
            end
        end else if (bus.flush) begin
            for (int u = 0; u < NSRC; u++) begin
                rd_ptr[u] <= '0;
                wr_ptr[u] <= '0;
                count[u]  <= '0;
            end
        end else begin
            for (int u = 0; u < NSRC; u++) begin
                if (pop[u]) begin
                    rd_ptr[u] <= rd_ptr[u] + PTR_W'(1);
                end
                if (push[u]) begin
                    wr_ptr[u] <= wr_ptr[u] + PTR_W'(1);
                end
                if (push[u] && !pop[u]) begin
                    count[u] <= count[u] + CNT_W'(1);
                end else if (pop[u] && !push[u]) begin
                    count[u] <= count[u] - CNT_W'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; the counts decide what is live.
    always_ff @(posedge clk) begin
        for (int u = 0; u < NSRC; u++) begin
            if (!bus.flush && push[u]) begin
                tag_mem[u][wr_ptr[u]]  <= bus.req_tag[u*TAG_W +: TAG_W];
                data_mem[u][wr_ptr[u]] <= bus.req_data[u*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else if (bus.flush) begin
            cdb_valid_q <= 1'b0;
        end else begin
            cdb_valid_q <= grant_valid;
            if (grant_valid) begin
                cdb_tag_q  <= cand_tag[grant_idx];
                cdb_data_q <= cand_data[grant_idx];
                cdb_src_q  <= grant_idx;
            end
        end
    end

    assign bus.full      = full_q;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;

`ifndef SYNTHESIS
    // Issue logic must never send a completion to a unit whose queue is full.
    always @(posedge clk) begin
        if (rst_n && !bus.flush) begin
            for (int u = 0; u < NSRC; u++) begin
                assert (!(bus.req_valid[u] && full_q[u]))
                    else $warning("cdb_arbiter: source %0d request dropped while queue full", u);
            end
        end
    end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter with DEPTH=2; expected values are hand-derived per scenario.
module tb_cdb_arbiter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    cdb_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
    endtask

    task automatic set_req(input int u, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
        bus.req_valid[u]           = 1'b1;
        bus.req_tag[u*TAG_W +: TAG_W] = tag;
        bus.req_data[u*XLEN +: XLEN]  = data;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        set_req(0, 5'd9, 32'h1234_5678);
        tick();
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %0b expected 0", bus.cdb_valid); end
        checks++;
        if (bus.cdb_tag !== 5'd0) begin failures++; $display("[TB] FAIL reset_tag got %0d expected 0", bus.cdb_tag); end
        checks++;
        if (bus.cdb_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_data got %h expected 0", bus.cdb_data); end
        checks++;
        if (bus.cdb_src !== 2'd0) begin failures++; $display("[TB] FAIL reset_src got %0d expected 0", bus.cdb_src); end
        checks++;
        if (bus.full !== 4'b0000) begin failures++; $display("[TB] FAIL reset_full got %b expected 0000", bus.full); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 5'd3, 32'hDEAD_BEEF);
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got %0b expected 1", bus.cdb_valid); end
        checks++;
        if (bus.cdb_tag !== 5'd3) begin failures++; $display("[TB] FAIL single_tag got %0d expected 3", bus.cdb_tag); end
        checks++;
        if (bus.cdb_data !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL single_data got %h expected deadbeef", bus.cdb_data); end
        checks++;
        if (bus.cdb_src !== 2'd0) begin failures++; $display("[TB] FAIL single_src got %0d expected 0", bus.cdb_src); end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_valid got %0b expected 0", bus.cdb_valid); end
        checks++;
        if (bus.cdb_tag !== 5'd3 || bus.cdb_data !== 32'hDEAD_BEEF) begin
            failures++; $display("[TB] FAIL single_hold got tag %0d data %h expected 3 deadbeef", bus.cdb_tag, bus.cdb_data);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int u = 0; u < 4; u++) set_req(u, 5'(u + 1), 32'hC0DE_0000 + u);
        for (int e = 0; e < 4; e++) begin
            tick();
            clear_inputs();
            checks++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'(e) || bus.cdb_tag !== 5'(e + 1)) begin
                failures++;
                $display("[TB] FAIL all4_grant[%0d] got v=%0b src=%0d tag=%0d expected v=1 src=%0d tag=%0d",
                         e, bus.cdb_valid, bus.cdb_src, bus.cdb_tag, e, e + 1);
            end
            checks++;
            if (bus.cdb_data !== 32'hC0DE_0000 + 32'(e)) begin failures++; $display("[TB] FAIL all4_data[%0d] got %h expected %h", e, bus.cdb_data, 32'hC0DE_0000 + 32'(e)); end
            checks++;
            if (bus.full !== 4'b0000) begin failures++; $display("[TB] FAIL all4_full[%0d] got %b expected 0000", e, bus.full); end
        end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin failures++; $display("[TB] FAIL all4_drain got %0b expected 0", bus.cdb_valid); end
        // Pointer should be back at 0: int beats mem.
        set_req(3, 5'd20, 32'h0000_0020);
        set_req(0, 5'd21, 32'h0000_0021);
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb_src !== 2'd0 || bus.cdb_tag !== 5'd21) begin failures++; $display("[TB] FAIL all4_ptr_first got src=%0d tag=%0d expected src=0 tag=21", bus.cdb_src, bus.cdb_tag); end
        tick();
        checks++;
        if (bus.cdb_src !== 2'd3 || bus.cdb_tag !== 5'd20) begin failures++; $display("[TB] FAIL all4_ptr_second got src=%0d tag=%0d expected src=3 tag=20", bus.cdb_src, bus.cdb_tag); end
        tick();
    endtask

    task automatic test_stream();
        int         exp_src  [7] = '{0, 1, 0, 1, 0, 1, 0};
        int         exp_tag  [7] = '{0, 16, 1, 17, 2, 18, 3};
        logic [3:0] exp_full [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] exp_data;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            clear_inputs();
            if (k <= 3) set_req(0, 5'(k), 32'h1000_0000 + k);
            if (k <= 2) set_req(1, 5'(16 + k), 32'h2000_0000 + k);
            tick();
            exp_data = (exp_src[k] == 0) ? 32'h1000_0000 + 32'(exp_tag[k]) : 32'h2000_0000 + 32'(exp_tag[k] - 16);
            checks++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'(exp_src[k]) || bus.cdb_tag !== 5'(exp_tag[k])) begin
                failures++;
                $display("[TB] FAIL stream_grant[%0d] got v=%0b src=%0d tag=%0d expected v=1 src=%0d tag=%0d",
                         k, bus.cdb_valid, bus.cdb_src, bus.cdb_tag, exp_src[k], exp_tag[k]);
            end
            checks++;
            if (bus.cdb_data !== exp_data) begin failures++; $display("[TB] FAIL stream_data[%0d] got %h expected %h", k, bus.cdb_data, exp_data); end
            checks++;
            if (bus.full !== exp_full[k]) begin failures++; $display("[TB] FAIL stream_full[%0d] got %b expected %b", k, bus.full, exp_full[k]); end
        end
        clear_inputs();
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 5'd3) begin failures++; $display("[TB] FAIL stream_end got v=%0b tag=%0d expected v=0 tag=3", bus.cdb_valid, bus.cdb_tag); end
    endtask

    task automatic test_full_drop();
        int   exp_src  [7] = '{0, 1, 2, 3, 0, 0, 0};
        int   exp_tag  [7] = '{1, 9, 10, 11, 2, 3, 0};
        logic exp_vld  [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic exp_full [7] = '{0, 0, 1, 1, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            clear_inputs();
            if (k == 0) begin
                set_req(0, 5'd1, 32'h5500_0001);
                set_req(1, 5'd9, 32'h5500_0009);
                set_req(2, 5'd10, 32'h5500_000A);
                set_req(3, 5'd11, 32'h5500_000B);
            end else if (k <= 3) begin
                set_req(0, 5'(k + 1), 32'h5500_0000 + k + 1);
            end
            tick();
            checks++;
            if (bus.cdb_valid !== exp_vld[k]) begin failures++; $display("[TB] FAIL drop_valid[%0d] got %0b expected %0b", k, bus.cdb_valid, exp_vld[k]); end
            checks++;
            if (bus.full !== {3'b000, exp_full[k]}) begin failures++; $display("[TB] FAIL drop_full[%0d] got %b expected 000%0b", k, bus.full, exp_full[k]); end
            if (exp_vld[k]) begin
                checks++;
                if (bus.cdb_src !== 2'(exp_src[k]) || bus.cdb_tag !== 5'(exp_tag[k]) || bus.cdb_data !== 32'h5500_0000 + 32'(exp_tag[k])) begin
                    failures++;
                    $display("[TB] FAIL drop_grant[%0d] got src=%0d tag=%0d data=%h expected src=%0d tag=%0d",
                             k, bus.cdb_src, bus.cdb_tag, bus.cdb_data, exp_src[k], exp_tag[k]);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int u = 0; u < 4; u++) set_req(u, 5'(u + 1), 32'hF000_0000 + u);
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0) begin failures++; $display("[TB] FAIL flush_pre got v=%0b src=%0d expected v=1 src=0", bus.cdb_valid, bus.cdb_src); end
        clear_inputs();
        bus.flush = 1'b1;
        set_req(0, 5'd7, 32'hF000_0007);
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got %0b expected 0", bus.cdb_valid); end
        checks++;
        if (bus.full !== 4'b0000) begin failures++; $display("[TB] FAIL flush_full got %b expected 0000", bus.full); end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_discard got %0b expected 0", bus.cdb_valid); end
        // Pointer was 1 before the flush and must survive it: mult beats int.
        set_req(0, 5'd12, 32'hF000_0012);
        set_req(1, 5'd13, 32'hF000_0013);
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1 || bus.cdb_tag !== 5'd13) begin
            failures++; $display("[TB] FAIL flush_ptr got v=%0b src=%0d tag=%0d expected v=1 src=1 tag=13", bus.cdb_valid, bus.cdb_src, bus.cdb_tag);
        end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0 || bus.cdb_tag !== 5'd12) begin
            failures++; $display("[TB] FAIL flush_next got v=%0b src=%0d tag=%0d expected v=1 src=0 tag=12", bus.cdb_valid, bus.cdb_src, bus.cdb_tag);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int u = 0; u < 4; u++) set_req(u, 5'(u + 1), 32'hAB00_0000 + u);
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 5'd1) begin failures++; $display("[TB] FAIL midrst_pre got v=%0b tag=%0d expected v=1 tag=1", bus.cdb_valid, bus.cdb_tag); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 5'd0 || bus.cdb_data !== 32'd0 || bus.cdb_src !== 2'd0 || bus.full !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midrst_async got v=%0b tag=%0d data=%h src=%0d full=%b expected all zero",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src, bus.full);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_empty got %0b expected 0", bus.cdb_valid); end
        set_req(0, 5'd6, 32'hAB00_0006);
        set_req(1, 5'd7, 32'hAB00_0007);
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0 || bus.cdb_tag !== 5'd6 || bus.cdb_data !== 32'hAB00_0006) begin
            failures++; $display("[TB] FAIL midrst_first got v=%0b src=%0d tag=%0d expected v=1 src=0 tag=6", bus.cdb_valid, bus.cdb_src, bus.cdb_tag);
        end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1 || bus.cdb_tag !== 5'd7) begin
            failures++; $display("[TB] FAIL midrst_second got v=%0b src=%0d tag=%0d expected v=1 src=1 tag=7", bus.cdb_valid, bus.cdb_src, bus.cdb_tag);
        end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_drain got %0b expected 0", bus.cdb_valid); end
    endtask

    task automatic test_prio();
        logic [1:0] first_src;
        logic [1:0] second_src;
`ifdef CDB_FIXED_PRIO_EN
        first_src  = 2'd2;
        second_src = 2'd0;
`else
        first_src  = 2'd0;
        second_src = 2'd2;
`endif
        do_reset();
        set_req(0, 5'd12, 32'h0000_0C0C);
        set_req(2, 5'd13, 32'h0000_0D0D);
        tick();
        clear_inputs();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== first_src) begin failures++; $display("[TB] FAIL prio_first got v=%0b src=%0d expected v=1 src=%0d", bus.cdb_valid, bus.cdb_src, first_src); end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== second_src) begin failures++; $display("[TB] FAIL prio_second got v=%0b src=%0d expected v=1 src=%0d", bus.cdb_valid, bus.cdb_src, second_src); end
        tick();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin failures++; $display("[TB] FAIL prio_drain got %0b expected 0", bus.cdb_valid); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_all_four();
        test_stream();
        test_full_drop();
        test_flush();
        test_mid_reset();
        test_prio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout got no finish expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end
endmodule
